fpdiv_seq: RTL and testbench

FPDIV_SEQ -- requirements
Module: fpdiv_seq

---
 rtl/fpdiv_seq.sv | 130 +++++++++++++
 tb/tb_fpdiv_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fpdiv_seq.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division,
// one quotient bit per cycle, fixed 28-cycle latency, truncating rounding.
module fpdiv_seq #(
  parameter logic [31:0] NAN_VAL = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] fquot,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t      state;
  logic [31:0] a_r, b_r;
  logic [24:0] q;
  logic [25:0] rem;
  logic [4:0]  cnt;

  assign dbg_state = state;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic [23:0] ma, mb;
  logic        sign;

  assign ea   = a_r[30:23];
  assign eb   = b_r[30:23];
  assign fa   = a_r[22:0];
  assign fb   = b_r[22:0];
  assign ma   = {1'b1, fa};
  assign mb   = {1'b1, fb};
  assign sign = a_r[31] ^ b_r[31];

  // One restoring step: the remainder stays below 2*mb, so 26 bits is ample.
  logic        rem_ge;
  logic [25:0] rem_sub;
  assign rem_ge  = (rem >= {2'b00, mb});
  assign rem_sub = rem_ge ? (rem - {2'b00, mb}) : rem;

  logic signed [9:0] e_base, e_norm;
  logic [22:0]       frac_n;
  assign e_base = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
  assign e_norm = q[24] ? e_base : (e_base - 10'sd1);
  assign frac_n = q[24] ? q[23:1] : q[22:0];

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

  logic [31:0] res;
  always_comb begin
    res = {sign, e_norm[7:0], frac_n};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      res = NAN_VAL;
    else if (a_inf)
      res = {sign, 8'hFF, 23'd0};
    else if (b_inf)
      res = {sign, 31'd0};
    else if (b_zero)
      res = {sign, 8'hFF, 23'd0};
    else if (a_zero)
      res = {sign, 31'd0};
    else if (e_norm >= 10'sd255)
      res = {sign, 8'hFF, 23'd0};
    else if (e_norm <= 10'sd0)
      res = {sign, 31'd0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fquot <= 32'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      q     <= 25'd0;
      rem   <= 26'd0;
      cnt   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            cnt   <= 5'd0;
            busy  <= 1'b1;
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          // cnt==0 loads the dividend; cnt 1..25 each produce one quotient bit.
          if (cnt == 5'd0) begin
            rem <= {2'b00, ma};
            q   <= 25'd0;
          end else begin
            q   <= {q[23:0], rem_ge};
            rem <= {rem_sub[24:0], 1'b0};
            if (cnt == 5'd25)
              state <= NORM;
          end
          cnt <= cnt + 5'd1;
        end
        NORM: begin
          fquot <= res;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv_seq.sv
// Bench for fpdiv_seq: directed vector table, randomized operands against an
// arithmetic reference model, and hand sequences for ignore/reset corners.
module tb_fpdiv_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a, b;
  logic [31:0] fquot;
  logic        busy, done;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fpdiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .fquot(fquot), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: quotient from integer arithmetic, then the special-case rules.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    int      ex, ey, e;
    longint  mx, my, qq;
    logic    s;
    logic [22:0] fr;
    bit xn, yn, xi, yi, xz, yz;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xz = (ex == 0);
    yz = (ey == 0);
    if (xn || yn || (xz && yz) || (xi && yi)) return 32'h7FC00000;
    if (xi) return {s, 8'hFF, 23'd0};
    if (yi) return {s, 31'd0};
    if (yz) return {s, 8'hFF, 23'd0};
    if (xz) return {s, 31'd0};
    mx = 64'h800000 + longint'(x[22:0]);
    my = 64'h800000 + longint'(y[22:0]);
    qq = (mx * 64'd16777216) / my;
    e  = ex - ey + 127;
    if (qq >= 64'd16777216) fr = 23'((qq / 2) % 64'h800000);
    else begin
      e  = e - 1;
      fr = 23'(qq % 64'h800000);
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), fr};
  endfunction

  // Issue one operation; operand inputs are scrambled after acceptance and an
  // optional second start is pulsed at cycle 5 with different operands.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input string name,
                        input bit second_start);
    int n;
    logic [31:0] held;
    exp_q.push_back(ref_div(av, bv));
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({name, " busy_after_accept"}, {31'd0, busy}, 32'd1);
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
      a = $urandom; b = $urandom;
      start = second_start && (n == 5);
    end
    start = 1'b0;
    check({name, " latency"}, n, 32'd28);
    check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
    held = exp_q.pop_front();
    check({name, " fquot"}, fquot, held);
    @(negedge clk);
    check({name, " done_pulse"}, {31'd0, done}, 32'd0);
    check({name, " fquot_hold"}, fquot, held);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    string       name;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int dn;
    logic [31:0] ra, rb;
    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, "6/2"};
    vecs[1]  = '{32'hC0933333, 32'hC0933333, 32'h3F800000, "neg_self"};
    vecs[2]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, "one_third"};
    vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, "one_by_zero"};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, "zero_by_zero"};
    vecs[5]  = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, "overflow"};
    vecs[6]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, "neg6/2"};
    vecs[7]  = '{32'h3F800000, 32'h7F800000, 32'h00000000, "one_by_inf"};
    vecs[8]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000, "ninf_by_one"};
    vecs[9]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_by_inf"};
    vecs[10] = '{32'h7FC12345, 32'h3F800000, 32'h7FC00000, "nan_in"};
    vecs[11] = '{32'h80000000, 32'h3F800000, 32'h80000000, "neg_zero"};
    vecs[12] = '{32'h00800000, 32'h7F000000, 32'h00000000, "underflow"};
    vecs[13] = '{32'h00000001, 32'h3F800000, 32'h00000000, "denormal"};

    reset = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_fquot", fquot, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      check({vecs[i].name, " model"}, ref_div(vecs[i].a, vecs[i].b), vecs[i].q);
      run_op(vecs[i].a, vecs[i].b, vecs[i].name, 1'b0);
    end

    // Second start at cycle 5 must be ignored.
    run_op(32'h40C00000, 32'h40000000, "ignore_start", 1'b1);

    // Reset at cycle 10 abandons the operation.
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_fquot", fquot, 32'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    check("midreset_no_done", dn, 32'd0);
    run_op(32'h3F800000, 32'h40400000, "after_reset", 1'b0);

    // Reset wins over start on the same edge.
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("reset_prio_busy", {31'd0, busy}, 32'd0);
    dn = 0;
    for (int i = 0; i < 35; i++) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    check("reset_prio_no_done", dn, 32'd0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0) begin
        ra[30:23] = 8'($urandom_range(100, 154));
        rb[30:23] = 8'($urandom_range(100, 154));
      end
      run_op(ra, rb, $sformatf("rand%0d", i), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
